// File: rtl/gcd_bcd_engine.sv
// gcd_bcd_engine: multi-cycle subtractive GCD followed by a sequential
// double-dabble binary-to-BCD conversion of the result. Results are held
// until the next completed operation.
//
// Ports:
//   CLK      system clock, rising edge
//   Reset    asynchronous active-high reset
//   S        start request, sampled only while idle
//   number1  operand A, captured on the accepting edge
//   number2  operand B, captured on the accepting edge
//   Busy     high while computing or converting
//   Done     one-cycle pulse when new results are presented
//   GCD      last GCD result, binary
//   BCD      last GCD result in BCD, BCD[3:0] is the ones digit
//   Error    last operation had both operands equal to zero
module gcd_bcd_engine #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  S,
  input  logic [WIDTH-1:0]      number1,
  input  logic [WIDTH-1:0]      number2,
  output logic                  Busy,
  output logic                  Done,
  output logic [WIDTH-1:0]      GCD,
  output logic [4*DIGITS-1:0]   BCD,
  output logic                  Error
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam longint unsigned MaxVal = (64'd1 << WIDTH) - 64'd1;

  // True when DIGITS decimal digits can represent every WIDTH-bit value.
  function automatic bit digits_fit();
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (p <= MaxVal) p = p * 64'd10;
    end
    return p > MaxVal;
  endfunction

  localparam bit ParamsOk = (WIDTH >= 2) && (WIDTH <= 32) && (DIGITS >= 1) && digits_fit();

  generate
    if (!ParamsOk) begin : g_bad_params
      $error("gcd_bcd_engine: need 2 <= WIDTH <= 32 and 10**DIGITS > 2**WIDTH-1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CONV
  } state_t;

  state_t            state_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [WIDTH-1:0]  r_q;    // GCD result kept intact for the GCD output
  logic [WIDTH-1:0]  sh_q;   // copy of the result shifted out into the BCD digits
  logic [BcdW-1:0]   bcd_q;
  logic [CntW-1:0]   cnt_q;

  logic              term_c;
  logic [WIDTH-1:0]  r_sel_c;
  logic [BcdW-1:0]   adj_c;
  logic [BcdW-1:0]   bcd_d;
  logic [WIDTH-1:0]  sh_d;
  logic              last_c;

  // GCD termination: a zero operand or equal operands ends the subtraction loop.
  always_comb begin
    term_c  = (a_q == '0) || (b_q == '0) || (a_q == b_q);
    r_sel_c = (a_q == '0) ? b_q : a_q;
  end

  // One double-dabble step: add 3 to digits >= 5, then shift {bcd, sh} left.
  always_comb begin
    adj_c = bcd_q;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) adj_c[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
    end
    bcd_d  = {adj_c[BcdW-2:0], sh_q[WIDTH-1]};
    sh_d   = {sh_q[WIDTH-2:0], 1'b0};
    last_c = (cnt_q == CntW'(WIDTH - 1));
  end

  // Control FSM and datapath registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      sh_q    <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      GCD     <= '0;
      BCD     <= '0;
      Error   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (S) begin
            a_q     <= number1;
            b_q     <= number2;
            Busy    <= 1'b1;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (term_c) begin
            r_q     <= r_sel_c;
            sh_q    <= r_sel_c;
            bcd_q   <= '0;
            cnt_q   <= '0;
            state_q <= ST_CONV;
          end else if (a_q > b_q) begin
            a_q <= a_q - b_q;
          end else begin
            b_q <= b_q - a_q;
          end
        end
        ST_CONV: begin
          bcd_q <= bcd_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CntW'(1);
          if (last_c) begin
            // a_q/b_q are frozen during conversion, so they still hold the terminal values.
            GCD     <= r_q;
            BCD     <= bcd_d;
            Error   <= (a_q == '0) && (b_q == '0);
            Done    <= 1'b1;
            Busy    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
